armleo_regfile_nr1w: RTL and testbench
======================================

// Module: armleo_regfile_nr1w
// PURPOSE
//   Parametrised register file: READ_PORTS synchronous read ports, one write port.
//   Generalises the 2-read/1-write core regfile for wider-issue pipelines.
//   A hardware clear engine zeroes every entry after reset, and a ready flag gates access.
//   Sits in the decode/operand-fetch stage; the issue logic must wait for ready.
// PARAMETERS
//   WIDTH       32  bits per register
//   DEPTH_LOG2  5   address width; DEPTH = 2**DEPTH_LOG2 entries
//   READ_PORTS  2   number of independent read ports, >=1
//   ZERO_REG    1   1: entry 0 is hardwired zero (writes to it dropped); 0: normal entry
// PORTS
//   clk       in   1                       clock, all state on rising edge
//   rst       in   1                       asynchronous reset, active-high
//   ready     out  1                       1 = clear done, reads/writes accepted
//   rs_read   in   READ_PORTS              per-port read enable
//   rs_addr   in   READ_PORTS*DEPTH_LOG2   port i address at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   rs_rdata  out  READ_PORTS*WIDTH        port i data at [i*WIDTH +: WIDTH], registered
//   rd_write  in   1                       write enable
//   rd_addr   in   DEPTH_LOG2              write address
//   rd_wdata  in   WIDTH                   write data
// BEHAVIOUR
//   Reset: ready=0, all rs_rdata=0, clear counter=0, FSM enters CLEAR. Memory array not reset.
//   FSM CLEAR: each cycle writes 0 to entry clear_cnt, then clear_cnt++.
//     After entry DEPTH-1 is written -> READY; ready=1 from the next cycle (DEPTH cycles total).
//     In CLEAR: rd_write and rs_read are ignored; rs_rdata holds 0.
//   FSM READY: terminal state; only rst leaves it. rst asserted mid-clear or in READY
//     restarts the clear from entry 0 (asynchronous).
//   Read: if ready && rs_read[i], then rs_rdata[i] <= mem[rs_addr[i]] at the edge (1-cycle latency).
//     If rs_read[i]=0, rs_rdata[i] holds its previous value. Ports are fully independent;
//     any ports may read the same address in the same cycle.
//   Write: if ready && rd_write && !(ZERO_REG && rd_addr==0), then mem[rd_addr] <= rd_wdata.
//   ZERO_REG=1: a read of address 0 returns 0 regardless of memory contents.
//   Read and write to the same address in the same cycle: see CONFIGURATION.
//   Address range: all 2**DEPTH_LOG2 addresses valid; there is no out-of-range case.
// CONFIGURATION
//   ARMLEO_REGFILE_BYPASS_EN defined: a read of rd_addr in the same cycle as an accepted write
//     returns rd_wdata (write-first forwarding, per port). A dropped write to entry 0 is not forwarded.
//   Not defined: the same-cycle read returns the old contents (read-first). No forwarding mux is built.
// STRUCTURE
//   Package armleo_regfile_pkg: FSM state enum (CLEAR, READY), localparam DEPTH,
//     and helper functions for port slice offsets.
//   Sub-module: armleo_mem_1r1w (existing). One instance per read port, all sharing the
//     muxed write port (clear engine or user write).
//   The top level holds the FSM, the clear counter, the write mux, zero-register masking
//     and the optional bypass mux.
// TESTING
//   1. rst pulse, default params -> ready=0 for exactly 32 cycles, rises on cycle 33;
//      every address then reads 0 on every port.
//   2. Write 0xDEADBEEF to addr 5; next cycle read addr 5 on ports 0 and 1
//      -> both return 0xDEADBEEF one cycle later.
//   3. Write 0x12345678 to addr 0 with ZERO_REG=1 -> read addr 0 returns 0.
//      With ZERO_REG=0 -> returns 0x12345678.
//   4. Same-cycle write 0xA5A5A5A5 to addr 7 (old value 0x11) and read addr 7 -> returns 0x11
//      without the macro, 0xA5A5A5A5 with ARMLEO_REGFILE_BYPASS_EN.
//   5. rst asserted at clear cycle 10 -> ready stays 0; a full 32-cycle clear restarts;
//      a write issued while ready=0 is absent afterwards.
//   6. READ_PORTS=4, all four ports read distinct addresses 1..4 (preloaded 0x1..0x4)
//      -> each port returns its own value; ports with rs_read=0 hold their prior data.

Source files
------------

// File: rtl/armleo_regfile_pkg.sv
// Shared definitions for the N-read / 1-write register file.
//   rf_state_e      : clear-engine FSM state (CLEAR while zeroing, READY afterwards)
//   DEPTH           : entry count of the default 5-bit-address configuration
//   rf_depth()      : entry count for a given address width
//   addr_off()      : bit offset of a read port's address field in the packed bus
//   data_off()      : bit offset of a read port's data field in the packed bus
package armleo_regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int unsigned DEPTH_LOG2_DEF = 5;
  localparam int unsigned DEPTH          = 1 << DEPTH_LOG2_DEF;

  function automatic int unsigned rf_depth(input int unsigned dl2);
    return 1 << dl2;
  endfunction

  function automatic int unsigned addr_off(input int unsigned port, input int unsigned dl2);
    return port * dl2;
  endfunction

  function automatic int unsigned data_off(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/armleo_mem_1r1w.sv
// Simple dual-port storage: one combinational read port, one synchronous write port.
// The array has no reset; the owner is responsible for initialising it.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (old contents on a same-cycle write, i.e. read-first)
module armleo_mem_1r1w #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/armleo_regfile_nr1w.sv
// Parametrised register file with READ_PORTS registered read ports and one write port.
// After reset a clear engine writes zero to every entry (one per cycle); ready rises
// once the last entry is cleared and only then are user reads/writes accepted.
// Optional feature macro: ARMLEO_REGFILE_BYPASS_EN (write-first forwarding per port).
//   clk      : clock, all state on rising edge
//   rst      : asynchronous reset, active-high; restarts the clear
//   ready    : 1 = clear done, access accepted
//   rs_read  : per-port read enable
//   rs_addr  : port i address at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   rs_rdata : port i registered data at [i*WIDTH +: WIDTH]
//   rd_write : write enable
//   rd_addr  : write address
//   rd_wdata : write data
module armleo_regfile_nr1w
  import armleo_regfile_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  input  logic [READ_PORTS-1:0]            rs_read,
  input  logic [READ_PORTS*DEPTH_LOG2-1:0] rs_addr,
  output logic [READ_PORTS*WIDTH-1:0]      rs_rdata,
  input  logic                             rd_write,
  input  logic [DEPTH_LOG2-1:0]            rd_addr,
  input  logic [WIDTH-1:0]                 rd_wdata
);

  rf_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] clear_cnt_q, clear_cnt_d;

  logic                  wr_accept;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    case (state_q)
      CLEAR: begin
        clear_cnt_d = clear_cnt_q + DEPTH_LOG2'(1);
        // all-ones counter == last entry being cleared this cycle
        if (&clear_cnt_q) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign ready = (state_q == READY);

  // Writes to entry 0 are dropped when it is hardwired zero, and are then never forwarded.
  assign wr_accept = ready && rd_write && !(ZERO_REG && (rd_addr == '0));

  // Shared write port: clear engine owns it until ready.
  assign mem_we    = !ready || wr_accept;
  assign mem_waddr = ready ? rd_addr  : clear_cnt_q;
  assign mem_wdata = ready ? rd_wdata : '0;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
    localparam int unsigned AO = addr_off(i, DEPTH_LOG2);
    localparam int unsigned DO = data_off(i, WIDTH);

    logic [DEPTH_LOG2-1:0] raddr;
    logic [WIDTH-1:0]      mem_rdata;
    logic [WIDTH-1:0]      fwd_rdata;
    logic [WIDTH-1:0]      rdata_q, rdata_d;

    assign raddr = rs_addr[AO +: DEPTH_LOG2];

    armleo_mem_1r1w #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
      .clk    (clk),
      .we_i   (mem_we),
      .waddr_i(mem_waddr),
      .wdata_i(mem_wdata),
      .raddr_i(raddr),
      .rdata_o(mem_rdata)
    );

`ifdef ARMLEO_REGFILE_BYPASS_EN
    assign fwd_rdata = (wr_accept && (rd_addr == raddr)) ? rd_wdata : mem_rdata;
`else
    assign fwd_rdata = mem_rdata;
`endif

    always_comb begin
      rdata_d = rdata_q;
      if (ready && rs_read[i]) begin
        rdata_d = (ZERO_REG && (raddr == '0)) ? '0 : fwd_rdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rs_rdata[DO +: WIDTH] = rdata_q;
  end

endmodule

// File: tb/tb_armleo_regfile_nr1w.sv
// Bench for armleo_regfile_nr1w: dut_a = 2 ports, ZERO_REG=1; dut_b = 4 ports, ZERO_REG=0.
module tb_armleo_regfile_nr1w;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ready_a, ready_b;
  logic [1:0]  rs_read_a;
  logic [9:0]  rs_addr_a;
  logic [63:0] rs_rdata_a;
  logic        rd_write_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_wdata_a;
  logic [3:0]   rs_read_b;
  logic [19:0]  rs_addr_b;
  logic [127:0] rs_rdata_b;
  logic         rd_write_b;
  logic [4:0]   rd_addr_b;
  logic [31:0]  rd_wdata_b;

  armleo_regfile_nr1w #(.WIDTH(32), .DEPTH_LOG2(5), .READ_PORTS(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .rs_read(rs_read_a), .rs_addr(rs_addr_a),
    .rs_rdata(rs_rdata_a), .rd_write(rd_write_a), .rd_addr(rd_addr_a), .rd_wdata(rd_wdata_a));

  armleo_regfile_nr1w #(.WIDTH(32), .DEPTH_LOG2(5), .READ_PORTS(4), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .rs_read(rs_read_b), .rs_addr(rs_addr_b),
    .rs_rdata(rs_rdata_b), .rd_write(rd_write_b), .rd_addr(rd_addr_b), .rd_wdata(rd_wdata_b));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               d;
    logic [3:0]       rd;
    logic [3:0][4:0]  ra;
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic [3:0][31:0] ex;
    string            nm;
  } vec_t;

  typedef struct {
    string       nm;
    int          d;
    int          port;
    logic [31:0] ex;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  function automatic vec_t mk(input int d, input logic [3:0] rd,
                              input logic [4:0] a0, a1, a2, a3,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] e0, e1, e2, e3, input string nm);
    vec_t v;
    v.d = d; v.rd = rd; v.ra = {a3, a2, a1, a0};
    v.we = we; v.wa = wa; v.wd = wd;
    v.ex = {e3, e2, e1, e0}; v.nm = nm;
    return v;
  endfunction

  task automatic idle();
    rs_read_a = '0; rs_addr_a = '0; rd_write_a = 1'b0; rd_addr_a = '0; rd_wdata_a = '0;
    rs_read_b = '0; rs_addr_b = '0; rd_write_b = 1'b0; rd_addr_b = '0; rd_wdata_b = '0;
  endtask

  // Wait for the edge, then compare everything queued for it.
  task automatic step();
    exp_t e;
    logic [31:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = (e.d == 0) ? rs_rdata_a[e.port*32 +: 32] : rs_rdata_b[e.port*32 +: 32];
      check($sformatf("%s p%0d", e.nm, e.port), act, e.ex);
    end
  endtask

  task automatic op(input vec_t v);
    exp_t e;
    int np;
    idle();
    if (v.d == 0) begin
      rs_read_a = v.rd[1:0]; rs_addr_a = {v.ra[1], v.ra[0]};
      rd_write_a = v.we; rd_addr_a = v.wa; rd_wdata_a = v.wd;
      np = 2;
    end else begin
      rs_read_b = v.rd; rs_addr_b = v.ra;
      rd_write_b = v.we; rd_addr_b = v.wa; rd_wdata_b = v.wd;
      np = 4;
    end
    for (int i = 0; i < np; i++) begin
      e.nm = v.nm; e.d = v.d; e.port = i; e.ex = v.ex[i];
      sb.push_back(e);
    end
    step();
  endtask

  // Count edges until ready; rdata must stay 0 and both DUTs must agree meanwhile.
  task automatic run_clear(input string nm);
    int cnt = 0;
    int bad = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (ready_a !== ready_b) bad++;
      if (ready_a !== 1'b1 && (rs_rdata_a !== '0 || rs_rdata_b !== '0)) bad++;
    end while (ready_a !== 1'b1 && cnt < 200);
    check({nm, " cycles"}, cnt, 32);
    check({nm, " rdata held 0"}, bad, 0);
  endtask

  logic [31:0] byp_a, byp_b;

  initial begin
`ifdef ARMLEO_REGFILE_BYPASS_EN
    byp_a = 32'hA5A5_A5A5; byp_b = 32'h0000_BEEF;
`else
    byp_a = 32'h0000_0011; byp_b = 32'h0000_0000;
`endif
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready_a", {31'd0, ready_a}, 32'd0);
    check("reset ready_b", {31'd0, ready_b}, 32'd0);
    check("reset rdata_a", rs_rdata_a[31:0] | rs_rdata_a[63:32], 32'd0);
    rst = 1'b0;
    run_clear("clear1");

    // Every address reads 0 on every port after the clear.
    for (int a = 0; a < 32; a++) begin
      op(mk(0, 4'b0011, 5'(a), 5'(a), 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 0, 0, 0, 0, "clr_a"));
      op(mk(1, 4'b1111, 5'(a), 5'(a), 5'(a), 5'(a), 1'b0, 5'd0, 32'd0, 0, 0, 0, 0, "clr_b"));
    end

    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, "a_wr5"));
    tbl.push_back(mk(0, 4'b0011, 5, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "a_rd5"));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "a_wr0_hold"));
    tbl.push_back(mk(0, 4'b0011, 0, 5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, "a_rd0_zero"));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 7, 32'h11, 0, 32'hDEADBEEF, 0, 0, "a_wr7"));
    tbl.push_back(mk(0, 4'b0011, 7, 5, 0, 0, 1, 7, 32'hA5A5A5A5, byp_a, 32'hDEADBEEF, 0, 0, "a_rw7_same"));
    tbl.push_back(mk(0, 4'b0010, 0, 7, 0, 0, 0, 0, 0, byp_a, 32'hA5A5A5A5, 0, 0, "a_rd7_after"));
    tbl.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, "a_rw0_nofwd"));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, "b_wr0"));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 0, "b_rd0"));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 5'(k), 32'(k), 32'h12345678, 0, 0, 0, "b_preload"));
    tbl.push_back(mk(1, 4'b1111, 1, 2, 3, 4, 0, 0, 0, 1, 2, 3, 4, "b_rd1234"));
    tbl.push_back(mk(1, 4'b0110, 0, 0, 3, 0, 0, 0, 0, 1, 32'h12345678, 3, 4, "b_partial_hold"));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 9, 0, 1, 9, 32'hBEEF, 1, 32'h12345678, byp_b, 4, "b_rw9_same"));
    tbl.push_back(mk(1, 4'b1111, 9, 9, 9, 9, 0, 0, 0, 32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF, "b_rd9_all"));
    foreach (tbl[i]) op(tbl[i]);

    // Reset clears rdata immediately, even while a clock edge has not occurred.
    rst = 1'b1;
    #2;
    check("async rst rdata_b", rs_rdata_b[31:0] | rs_rdata_b[127:96], 32'd0);
    check("async rst ready_a", {31'd0, ready_a}, 32'd0);
    rst = 1'b0;
    // Hammer writes/reads during the clear; all must be ignored.
    rd_write_a = 1'b1; rd_addr_a = 5'd12; rd_wdata_a = 32'h55;
    rs_read_a = 2'b11; rs_addr_a = {5'd5, 5'd5};
    rd_write_b = 1'b1; rd_addr_b = 5'd12; rd_wdata_b = 32'h66;
    rs_read_b = 4'b1111; rs_addr_b = {5'd9, 5'd9, 5'd9, 5'd9};
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("midclear ready_a", {31'd0, ready_a}, 32'd0);
    rst = 1'b1;
    #2;
    check("midclear rst ready_b", {31'd0, ready_b}, 32'd0);
    rst = 1'b0;
    run_clear("clear_restart");
    idle();
    op(mk(0, 4'b0011, 12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, "a_after_restart"));
    op(mk(1, 4'b1111, 12, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, "b_after_restart"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
